// File: rtl/swap_sched_pkg.sv
// swap_sched_pkg: state encoding and default geometry shared by swap_sched and its arbiter
package swap_sched_pkg;
    localparam int DEF_NREQ  = 2;
    localparam int DEF_DW    = 8;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_AW    = 2;

    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_LATCH  = 2'd1;
    localparam state_t S_COMMIT = 2'd2;

    // requester id width, never narrower than one bit
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/swap_sched_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over NREQ requests, pointer advances past each winner
module rr_arbiter
    import swap_sched_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = id_width(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   id
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] j;

    // scan from the farthest slot back toward ptr so the nearest request overwrites the rest
    always_comb begin
        gnt = '0;
        id  = '0;
        j   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % NREQ);
            if (req[j]) begin
                gnt    = '0;
                gnt[j] = 1'b1;
                id     = j;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (en && |req)
            ptr <= (int'(id) == NREQ - 1) ? '0 : id + 1'b1;
    end
endmodule

// File: rtl/swap_sched.sv
// swap_sched: register file with arbitrated two-entry swap requests plus a config write port
module swap_sched
    import swap_sched_pkg::*;
#(
    parameter int NREQ  = DEF_NREQ,
    parameter int DW    = DEF_DW,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = DEF_AW,
    localparam int IW   = id_width(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*AW-1:0] req_idx_a,
    input  logic [NREQ*AW-1:0] req_idx_b,
    output logic [NREQ-1:0]    req_ready,
    output logic               done,
    output logic [IW-1:0]      done_id,
    output logic               busy,
    input  logic               cfg_we,
    input  logic [AW-1:0]      cfg_addr,
    input  logic [DW-1:0]      cfg_wdata,
    output logic               cfg_ready,
    input  logic [AW-1:0]      rd_addr,
    output logic [DW-1:0]      rd_data
);
    state_t          state, state_nxt;
    logic [DW-1:0]   rf [DEPTH];
    logic [DW-1:0]   tmp_a, tmp_b;
    logic [AW-1:0]   idx_a, idx_b, sel_a, sel_b;
    logic [IW-1:0]   id_q, gnt_id;
    logic [NREQ-1:0] gnt;
    logic            arb_en, take, in_range;

    function automatic logic ok(input logic [AW-1:0] i);
        return int'(i) < DEPTH;
    endfunction

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] i);
        return ok(i) ? rf[i] : '0;
    endfunction

    rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid),
        .en    (arb_en),
        .gnt   (gnt),
        .id    (gnt_id)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = (state == S_IDLE)  ? (take ? S_LATCH : S_IDLE) :
                    (state == S_LATCH) ? S_COMMIT : S_IDLE;
    end

    // a config write in IDLE blocks the grant for that cycle
    always_comb begin
        busy      = state != S_IDLE;
        cfg_ready = state == S_IDLE;
        arb_en    = cfg_ready && !cfg_we;
        take      = arb_en && |req_valid;
        req_ready = arb_en ? gnt : '0;
    end

    assign sel_a   = req_idx_a[gnt_id*AW +: AW];
    assign sel_b   = req_idx_b[gnt_id*AW +: AW];
    assign rd_data = rd(rd_addr);

    // out-of-range swaps still run the sequence and pulse done, but leave rf untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                rf[i] <= '0;
            tmp_a    <= '0;
            tmp_b    <= '0;
            idx_a    <= '0;
            idx_b    <= '0;
            id_q     <= '0;
            in_range <= 1'b0;
            done     <= 1'b0;
            done_id  <= '0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE && cfg_we && ok(cfg_addr))
                rf[cfg_addr] <= cfg_wdata;
            if (take) begin
                id_q     <= gnt_id;
                idx_a    <= sel_a;
                idx_b    <= sel_b;
                in_range <= ok(sel_a) && ok(sel_b);
            end
            if (state == S_LATCH) begin
                tmp_a <= rd(idx_a);
                tmp_b <= rd(idx_b);
            end
            if (state == S_COMMIT) begin
                if (in_range) begin
                    rf[idx_a] <= tmp_b;
                    rf[idx_b] <= tmp_a;
                end
                done    <= 1'b1;
                done_id <= id_q;
            end
        end
    end
endmodule

// File: tb/tb_swap_sched.sv
// tb_swap_sched: directed scenarios then random traffic, checked against a cycle-count swap model
module tb_swap_sched;
    localparam int NREQ = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req_valid = '0;
    logic [3:0] req_idx_a = '0;
    logic [3:0] req_idx_b = '0;
    logic [1:0] req_ready;
    logic       done;
    logic [0:0] done_id;
    logic       busy;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_addr = '0;
    logic [7:0] cfg_wdata = '0;
    logic       cfg_ready;
    logic [1:0] rd_addr = '0;
    logic [7:0] rd_data;

    int checks = 0;
    int errors = 0;

    // model: entries as ints, a countdown for an in-flight swap, and a next-first pointer
    int m_rf[4];
    int m_ptr, m_cnt, m_id, m_a, m_b, m_done_id, g, tmp;
    bit m_done;
    int dut_gnts[$];

    swap_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_idx_a (req_idx_a),
        .req_idx_b (req_idx_b),
        .req_ready (req_ready),
        .done      (done),
        .done_id   (done_id),
        .busy      (busy),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_ready (cfg_ready),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick();
        if (m_cnt != 0 || cfg_we) return -1;
        for (int k = 0; k < NREQ; k++)
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) m_rf[i] = 0;
        m_ptr = 0; m_cnt = 0; m_done = 0; m_done_id = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        g = pick();
        chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        chk("busy", busy, m_cnt != 0);
        chk("cfg_ready", cfg_ready, m_cnt == 0);
        chk("done", done, m_done);
        if (m_done) chk("done_id", done_id, m_done_id);
        chk("rd_data", rd_data, m_rf[rd_addr]);
        if (req_ready == 2'b01) dut_gnts.push_back(0);
        if (req_ready == 2'b10) dut_gnts.push_back(1);
        @(posedge clk);
        m_done = 0;
        if (m_cnt == 0) begin
            if (cfg_we) m_rf[cfg_addr] = cfg_wdata;
            else if (g >= 0) begin
                m_id = g;
                m_a = req_idx_a[g*2 +: 2];
                m_b = req_idx_b[g*2 +: 2];
                m_ptr = (g + 1) % NREQ;
                m_cnt = 2;
            end
        end else if (m_cnt == 2) m_cnt = 1;
        else begin
            tmp = m_rf[m_a]; m_rf[m_a] = m_rf[m_b]; m_rf[m_b] = tmp;
            m_cnt = 0; m_done = 1; m_done_id = m_id;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        cfg_we = 1'b0;
        #2;
        model_clear();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_done_id", done_id, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rd", rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] a, input logic [7:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        cycle();
        cfg_we = 1'b0;
    endtask

    task automatic check_rf();
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            cycle();
        end
    endtask

    task automatic peek(input string tag, input logic [1:0] a, input logic [7:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        int p0;
        model_clear();
        do_reset();
        // reset clears a loaded file
        cfg(0, 8'h11); cfg(1, 8'h22); cfg(2, 8'h33); cfg(3, 8'h44);
        check_rf();
        peek("t1_load", 2'd2, 8'h33);
        do_reset();
        check_rf();
        // single swap 0<->3 by requester 0
        cfg(0, 8'hA5); cfg(3, 8'h5A);
        req_valid = 2'b01; req_idx_a = 4'b00_00; req_idx_b = 4'b00_11;
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        peek("t2_rf0", 2'd0, 8'h5A);
        peek("t2_rf3", 2'd3, 8'hA5);
        // both requesters held: grants alternate
        dut_gnts.delete();
        p0 = m_ptr;
        req_valid = 2'b11; req_idx_a = 4'b01_00; req_idx_b = 4'b10_11;
        repeat (12) cycle();
        req_valid = '0;
        repeat (3) cycle();
        chk("t3_count", dut_gnts.size(), 4);
        foreach (dut_gnts[i]) chk("t3_fair", dut_gnts[i], (p0 + i) % 2);
        // cfg beats a same-cycle request; cfg during busy waits for IDLE
        cfg_we = 1'b1; cfg_addr = 2'd1; cfg_wdata = 8'hC3;
        req_valid = 2'b10; req_idx_a = 4'b00_00; req_idx_b = 4'b01_00;
        cycle();
        cfg_we = 1'b0;
        cycle();
        req_valid = '0;
        cfg_we = 1'b1; cfg_addr = 2'd2; cfg_wdata = 8'h99;
        cycle();
        cycle();
        cycle();
        cfg_we = 1'b0;
        peek("t4_rf0", 2'd0, 8'hC3);
        peek("t4_rf2", 2'd2, 8'h99);
        check_rf();
        // A == B leaves the entry alone but still completes
        cfg(2, 8'h7E);
        req_valid = 2'b10; req_idx_a = 4'b10_00; req_idx_b = 4'b10_00;
        cycle();
        req_valid = '0;
        repeat (3) cycle();
        peek("t5_rf2", 2'd2, 8'h7E);
        // reset during LATCH abandons the swap
        cfg(0, 8'h12); cfg(1, 8'h34);
        req_valid = 2'b01; req_idx_a = 4'b00_00; req_idx_b = 4'b00_01;
        cycle();
        req_valid = '0;
        do_reset();
        repeat (3) cycle();
        check_rf();
        peek("t6_rf1", 2'd1, 8'h00);
        // random traffic
        for (int n = 0; n < 400; n++) begin
            req_valid = 2'($urandom);
            req_idx_a = 4'($urandom);
            req_idx_b = 4'($urandom);
            cfg_we    = ($urandom_range(0, 5) == 0);
            cfg_addr  = 2'($urandom);
            cfg_wdata = 8'($urandom);
            rd_addr   = 2'($urandom);
            cycle();
        end
        req_valid = '0;
        cfg_we = 1'b0;
        repeat (3) cycle();
        check_rf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
